reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural integer register file: 32 x `WORD_W.
- Consumes the writeback stage's commit interface (dest enable, register index, data) on its write port.
- Serves two registered read ports to the decode stage, with write-to-read bypass and stall hold.
- x0 is hardwired to zero.

Parameters:
- NUM_REGS, 32, number of architectural registers; index width is `REG_IDX_W.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a read of the same index; when 0 the read returns the old value.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset; asynchronous, active-high.
- i_wr_en  in  1  write enable, driven by the writeback stage's dest-enable output.
- i_wr_reg  in  `REG_IDX_W  write index.
- i_wr_data  in  `WORD_W  write data.
- i_stall  in  1  decode stall; read outputs hold while high.
- i_rs1  in  `REG_IDX_W  read port 1 index.
- i_rs2  in  `REG_IDX_W  read port 2 index.
- o_rs1_data  out  `WORD_W  read port 1 data, registered.
- o_rs2_data  out  `WORD_W  read port 2 data, registered.

Behaviour:
- Reset (clr=1, asynchronous): all registers, o_rs1_data, o_rs2_data and the latched indices go to 0 immediately. Writes are ignored while clr is high.
- Write: at the rising edge, if i_wr_en=1 and i_wr_reg!=0, then reg[i_wr_reg] <= i_wr_data. Writes to x0 are discarded. Writes are accepted regardless of i_stall.
- Read, not stalled (i_stall=0), one-cycle latency:
  - At the edge, latch r_rsN_idx <= i_rsN.
  - o_rsN_data <= 0 if i_rsN==0.
  - Otherwise, if BYPASS=1 and i_wr_en=1 and i_wr_reg==i_rsN, o_rsN_data <= i_wr_data.
  - Otherwise, o_rsN_data <= reg[i_rsN].
- Read, stalled (i_stall=1):
  - Indices and outputs hold.
  - Exception: if i_wr_en=1, i_wr_reg!=0 and i_wr_reg==r_rsN_idx, then o_rsN_data <= i_wr_data, regardless of BYPASS. Held operands must never go stale.
- Both ports are independent. rs1==rs2 is legal and both receive identical data.
- Stall released: the next edge samples the new i_rsN normally.
- Reset mid-stall: outputs go to 0; the latched index goes to 0 (x0), so held data stays 0 until the first unstalled edge.
- Out-of-range index (NUM_REGS<2^`REG_IDX_W): the read returns 0 and the write is discarded.
- The array is not reset-read-combinational. Only the registered outputs are visible to the pipeline.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- Defined: adds ports i_dbg_reg (in, `REG_IDX_W) and o_dbg_data (out, `WORD_W).
  - o_dbg_data is a combinational read of reg[i_dbg_reg], with no bypass; x0 reads 0.
  - Used by the testbench and trace dumps to inspect architectural state alongside the pipeline's pc/instr trace.
- Undefined: ports absent, no extra logic.

Decomposition:
- `WORD_W and `REG_IDX_W come from config.vh; add `NUM_REGS there.
- Add `REG_ZERO (index 0) as a shared constant.
- No sub-module. A single read-port mux/bypass function is reused for both ports. An optional reg_file_rd_port sub-module is acceptable but not required.

Test Plan:
- Reset check: assert clr mid-cycle -> o_rs1_data, o_rs2_data = 0 immediately. Debug read of every index = 0.
- Basic write then read: write x5=0xDEADBEEF, then next cycle i_rs1=5 -> o_rs1_data=0xDEADBEEF one edge later.
- x0 write discarded: write x0=0x12345678, then read rs1=0, rs2=0 -> both outputs 0.
- Same-cycle bypass:
  - BYPASS=1: write x7=0xA5A5A5A5 while i_rs2=7 (old x7=0x11) -> o_rs2_data=0xA5A5A5A5.
  - BYPASS=0: same stimulus -> o_rs2_data=0x11.
- Stall hold with update: latch rs1=3 (x3=0x10) and raise i_stall. Write x3=0x20, then change i_rs1=9 -> o_rs1_data=0x20. Release the stall -> next edge o_rs1_data=reg[9].
- Reset during stall: stall with o_rs1_data=0x20 and assert clr -> output 0. Write x3=0x30 while still stalled after clr falls -> output remains 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths, index constants and types for the architectural integer register file.
package reg_file_pkg;

  localparam int unsigned WordW   = 32;
  localparam int unsigned RegIdxW = 5;
  localparam int unsigned NumRegs = 32;

  typedef logic [WordW-1:0]   word_t;
  typedef logic [RegIdxW-1:0] reg_idx_t;

  localparam reg_idx_t RegZero = '0;

endpackage

// File: rtl/reg_file_if.sv
// Writeback commit port, decode read ports and stall for reg_file.
// Optional debug read port is present when REGFILE_DBG_EN is defined.
interface reg_file_if;
  import reg_file_pkg::*;

  logic     wr_en;
  reg_idx_t wr_reg;
  word_t    wr_data;
  logic     stall;
  reg_idx_t rs1;
  reg_idx_t rs2;
  word_t    rs1_data;
  word_t    rs2_data;
`ifdef REGFILE_DBG_EN
  reg_idx_t dbg_reg;
  word_t    dbg_data;
`endif

  modport master (
    output wr_en, wr_reg, wr_data, stall, rs1, rs2,
    input  rs1_data, rs2_data
`ifdef REGFILE_DBG_EN
    , output dbg_reg
    , input  dbg_data
`endif
  );

  modport slave (
    input  wr_en, wr_reg, wr_data, stall, rs1, rs2,
    output rs1_data, rs2_data
`ifdef REGFILE_DBG_EN
    , input  dbg_reg
    , output dbg_data
`endif
  );

endinterface

// File: rtl/reg_file.sv
// Architectural register file: one write port, two registered read ports with bypass and
// stall hold; x0 reads zero. REGFILE_DBG_EN adds a combinational debug read port.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned Regs   = NumRegs,
  parameter bit          Bypass = 1'b1
) (
  input logic       clk,
  input logic       clr,
  reg_file_if.slave rf
);

  word_t    regs_q [Regs];
  word_t    regs_d [Regs];
  reg_idx_t rs1_idx_q, rs1_idx_d;
  reg_idx_t rs2_idx_q, rs2_idx_d;
  word_t    rs1_data_q, rs1_data_d;
  word_t    rs2_data_q, rs2_data_d;
  word_t    rs1_arr, rs2_arr;
  logic     wr_ok;

  function automatic logic in_range(input reg_idx_t idx);
    return 32'(idx) < Regs;
  endfunction

  // Shared by both read ports. While stalled the held operand still tracks commits to
  // its latched index so decode never consumes stale data.
  function automatic word_t port_next(input logic     stall,
                                      input reg_idx_t rs,
                                      input reg_idx_t idx_q,
                                      input word_t    data_q,
                                      input word_t    arr_val,
                                      input logic     wr_hit,
                                      input reg_idx_t wr_reg,
                                      input word_t    wr_data);
    word_t nxt;
    nxt = data_q;
    if (stall) begin
      if (wr_hit && wr_reg == idx_q) nxt = wr_data;
    end else if (rs == RegZero || !in_range(rs)) begin
      nxt = '0;
    end else if (Bypass && wr_hit && wr_reg == rs) begin
      nxt = wr_data;
    end else begin
      nxt = arr_val;
    end
    return nxt;
  endfunction

  assign wr_ok   = rf.wr_en && (rf.wr_reg != RegZero) && in_range(rf.wr_reg);
  assign rs1_arr = in_range(rf.rs1) ? regs_q[rf.rs1] : '0;
  assign rs2_arr = in_range(rf.rs2) ? regs_q[rf.rs2] : '0;

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[rf.wr_reg] = rf.wr_data;

    rs1_idx_d  = rf.stall ? rs1_idx_q : rf.rs1;
    rs2_idx_d  = rf.stall ? rs2_idx_q : rf.rs2;
    rs1_data_d = port_next(rf.stall, rf.rs1, rs1_idx_q, rs1_data_q, rs1_arr,
                           wr_ok, rf.wr_reg, rf.wr_data);
    rs2_data_d = port_next(rf.stall, rf.rs2, rs2_idx_q, rs2_data_q, rs2_arr,
                           wr_ok, rf.wr_reg, rf.wr_data);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < int'(Regs); i++) regs_q[i] <= '0;
      rs1_idx_q  <= RegZero;
      rs2_idx_q  <= RegZero;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      regs_q     <= regs_d;
      rs1_idx_q  <= rs1_idx_d;
      rs2_idx_q  <= rs2_idx_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  assign rf.rs1_data = rs1_data_q;
  assign rf.rs2_data = rs2_data_q;

`ifdef REGFILE_DBG_EN
  assign rf.dbg_data = (rf.dbg_reg == RegZero || !in_range(rf.dbg_reg)) ? '0
                                                                         : regs_q[rf.dbg_reg];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: bypass and no-bypass instances driven in lockstep
// against an array-based reference model; directed cases followed by random traffic.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_reg = '0;
  logic [31:0] wr_data = '0;
  logic        stall = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural array plus per-variant outputs [bypass][port].
  logic [31:0] m_reg [32];
  logic [31:0] m_out [2][2];
  logic [4:0]  m_idx [2];

  reg_file_if rf_b ();
  reg_file_if rf_n ();

  assign rf_b.wr_en   = wr_en;
  assign rf_b.wr_reg  = wr_reg;
  assign rf_b.wr_data = wr_data;
  assign rf_b.stall   = stall;
  assign rf_b.rs1     = rs1;
  assign rf_b.rs2     = rs2;
  assign rf_n.wr_en   = wr_en;
  assign rf_n.wr_reg  = wr_reg;
  assign rf_n.wr_data = wr_data;
  assign rf_n.stall   = stall;
  assign rf_n.rs1     = rs1;
  assign rf_n.rs2     = rs2;

`ifdef REGFILE_DBG_EN
  logic [4:0] dbg_reg = '0;
  assign rf_b.dbg_reg = dbg_reg;
  assign rf_n.dbg_reg = dbg_reg;
`endif

  reg_file #(.Bypass(1'b1)) u_byp   (.clk(clk), .clr(clr), .rf(rf_b));
  reg_file #(.Bypass(1'b0)) u_nobyp (.clk(clk), .clr(clr), .rf(rf_n));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int b = 0; b < 2; b++) begin
      m_out[b][0] = '0;
      m_out[b][1] = '0;
    end
    m_idx[0] = '0;
    m_idx[1] = '0;
  endtask

  // One rising edge of the architectural behaviour, using the current inputs.
  task automatic model_edge();
    logic       commit;
    logic [4:0] rs [2];
    commit = wr_en && (wr_reg != 0);
    rs[0]  = rs1;
    rs[1]  = rs2;
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 2; p++) begin
        if (stall) begin
          if (commit && wr_reg == m_idx[p]) m_out[b][p] = wr_data;
        end else if (rs[p] == 0) begin
          m_out[b][p] = '0;
        end else if (b == 1 && wr_en && wr_reg == rs[p]) begin
          m_out[b][p] = wr_data;
        end else begin
          m_out[b][p] = m_reg[rs[p]];
        end
      end
    end
    if (!stall) begin
      m_idx[0] = rs1;
      m_idx[1] = rs2;
    end
    if (commit) m_reg[wr_reg] = wr_data;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_b_rs1"}, rf_b.rs1_data, m_out[1][0]);
    check_eq({tag, "_b_rs2"}, rf_b.rs2_data, m_out[1][1]);
    check_eq({tag, "_n_rs1"}, rf_n.rs1_data, m_out[0][0]);
    check_eq({tag, "_n_rs2"}, rf_n.rs2_data, m_out[0][1]);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
`ifdef REGFILE_DBG_EN
    check_eq({tag, "_dbg"}, rf_b.dbg_data, m_reg[dbg_reg]);
`endif
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic st, input logic [4:0] r1, input logic [4:0] r2);
    wr_en   = we;
    wr_reg  = wr;
    wr_data = wd;
    stall   = st;
    rs1     = r1;
    rs2     = r2;
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    clr = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
`ifdef REGFILE_DBG_EN
    for (int i = 0; i < 32; i++) begin
      dbg_reg = 5'(i);
      #1;
      check_eq({tag, "_dbg_all"}, rf_b.dbg_data, 32'h0);
    end
`endif
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    step("wr_x5");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    step("rd_x5");
    check_eq("x5_read", rf_b.rs1_data, 32'hDEADBEEF);

    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
    step("wr_x0");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    step("rd_x0");
    check_eq("x0_rs1", rf_b.rs1_data, 32'h0);
    check_eq("x0_rs2", rf_b.rs2_data, 32'h0);

    drive(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0);
    step("wr_x7");
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7);
    step("bypass");
    check_eq("bypass_on",  rf_b.rs2_data, 32'hA5A5A5A5);
    check_eq("bypass_off", rf_n.rs2_data, 32'h11);

    drive(1'b1, 5'd3, 32'h10, 1'b0, 5'd0, 5'd0);
    step("wr_x3");
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd3, 5'd0);
    step("rd_x3");
    check_eq("x3_latched", rf_b.rs1_data, 32'h10);
    drive(1'b1, 5'd3, 32'h20, 1'b1, 5'd9, 5'd0);
    step("stall_upd");
    check_eq("stall_upd_b", rf_b.rs1_data, 32'h20);
    check_eq("stall_upd_n", rf_n.rs1_data, 32'h20);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd0);
    step("unstall");
    check_eq("unstall_x9", rf_b.rs1_data, 32'h99);

    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd0);
    step("relatch_x3");
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    step("hold_x3");
    check_eq("hold_x3", rf_b.rs1_data, 32'h20);
    do_reset("rst_stall");
    drive(1'b1, 5'd3, 32'h30, 1'b1, 5'd3, 5'd0);
    step("post_rst");
    check_eq("post_rst_b", rf_b.rs1_data, 32'h0);
    check_eq("post_rst_n", rf_n.rs1_data, 32'h0);

    for (int n = 0; n < 600; n++) begin
      logic [4:0] wr;
      wr = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, wr, $urandom, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)));
`ifdef REGFILE_DBG_EN
      dbg_reg = 5'($urandom_range(0, 31));
`endif
      step("rand");
      if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
